// File: rtl/rsa_pkg.sv
// Shared types for the RSA pipeline stages: search FSM states and default LFSR taps.
package rsa_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCand,
        StTest,
        StDiv,
        StReject,
        StAccept,
        StDone
    } state_e;

    // x^8 + x^6 + x^5 + x^4 + 1, right-shifting Galois form
    localparam logic [7:0] DefaultTaps = 8'hB8;

endpackage

// File: rtl/seq_mod.sv
// Restoring remainder unit: one quotient bit per cycle, done pulses WIDTH cycles after start.
module seq_mod #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] rem
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    function automatic logic [WIDTH-1:0] rem_step(input logic [WIDTH-1:0] r, input logic b,
                                                  input logic [WIDTH-1:0] dv);
        logic [WIDTH:0] t;
        t = {r, b};
        if (t >= {1'b0, dv}) begin
            t = t - {1'b0, dv};
        end
        return t[WIDTH-1:0];
    endfunction

    // The first bit is processed on the start edge so the last lands WIDTH-1 edges later.
    always_comb begin
        busy_d = busy_q;
        done_d = 1'b0;
        cnt_d  = cnt_q;
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        rem_d  = rem_q;
        if (start && !busy_q) begin
            rem_d  = rem_step('0, dividend[WIDTH-1], divisor);
            dvd_d  = dividend << 1;
            dvs_d  = divisor;
            cnt_d  = CW'(WIDTH - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            rem_d = rem_step(rem_q, dvd_q[WIDTH-1], dvs_q);
            dvd_d = dvd_q << 1;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            rem_q  <= rem_d;
        end
    end

    assign done = done_q;
    assign rem  = rem_q;

endmodule

// File: rtl/prime_pair_gen.sv
// Seeded search for two distinct full-width odd primes using an LFSR candidate
// sequence and trial division by odd divisors.
module prime_pair_gen
    import rsa_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DefaultTaps)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DW = WIDTH / 2 + 2;
    localparam int unsigned SW = WIDTH + 4;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [DW-1:0]    d_q, d_d;
    logic             phase_q, phase_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             done_q, done_d;

    logic             mod_start;
    logic             mod_done;
    logic [WIDTH-1:0] mod_rem;
    logic [WIDTH-1:0] lfsr_step;
    logic [SW-1:0]    d_ext;
    logic [SW-1:0]    d_sq;

    assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    assign d_ext     = SW'(d_q);
    assign d_sq      = d_ext * d_ext;

    seq_mod #(
        .WIDTH(WIDTH)
    ) u_seq_mod (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (mod_start),
        .dividend (cand_q),
        .divisor  (WIDTH'(d_q)),
        .done     (mod_done),
        .rem      (mod_rem)
    );

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        cand_d    = cand_q;
        d_d       = d_q;
        phase_d   = phase_q;
        p_d       = p_q;
        q_d       = q_q;
        done_d    = 1'b0;
        mod_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    lfsr_d  = (seed == '0) ? WIDTH'(1) : seed;
                    phase_d = 1'b0;
                    state_d = StCand;
                end
            end
            StCand: begin
                cand_d  = {1'b1, lfsr_q[WIDTH-2:1], 1'b1};
                d_d     = DW'(3);
                state_d = StTest;
            end
            StTest: begin
                if (d_sq > SW'(cand_q)) begin
                    state_d = StAccept;
                end else begin
                    mod_start = 1'b1;
                    state_d   = StDiv;
                end
            end
            StDiv: begin
                if (mod_done) begin
                    if (mod_rem == '0) begin
                        state_d = StReject;
                    end else begin
                        d_d     = d_q + DW'(2);
                        state_d = StTest;
                    end
                end
            end
            StReject: begin
                lfsr_d  = lfsr_step;
                state_d = StCand;
            end
            StAccept: begin
                // A repeat of p in the second phase is skipped so q always differs.
                if (!phase_q) begin
                    p_d     = cand_q;
                    phase_d = 1'b1;
                    lfsr_d  = lfsr_step;
                    state_d = StCand;
                end else if (cand_q == p_q) begin
                    lfsr_d  = lfsr_step;
                    state_d = StCand;
                end else begin
                    q_d     = cand_q;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            lfsr_q  <= WIDTH'(1);
            cand_q  <= '0;
            d_q     <= '0;
            phase_q <= 1'b0;
            p_q     <= '0;
            q_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cand_q  <= cand_d;
            d_q     <= d_d;
            phase_q <= phase_d;
            p_q     <= p_d;
            q_q     <= q_d;
            done_q  <= done_d;
        end
    end

    assign p    = p_q;
    assign q    = q_q;
    assign done = done_q;
    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_prime_pair_gen.sv
// Directed and random-seed bench for prime_pair_gen against an arithmetic search model.
module tb_prime_pair_gen;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] seed;
    logic [W-1:0] p;
    logic [W-1:0] q;
    logic         busy;
    logic         done;

    int n_cmp;
    int n_fail;
    int done_cnt;

    prime_pair_gen #(
        .WIDTH(W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .seed  (seed),
        .p     (p),
        .q     (q),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int i = 2; i < n; i++) begin
            if (n % i == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Walks the candidate sequence with plain arithmetic; cyc counts cycles from
    // the start edge to the cycle in which done is high.
    function automatic void model(input int s, output int mp, output int mq, output int cyc);
        int  l;
        int  cand;
        int  d;
        bit  prime;
        bit  have_p;
        l      = (s == 0) ? 1 : s;
        have_p = 1'b0;
        cyc    = 0;
        mp     = 0;
        mq     = 0;
        for (int g = 0; g < 1000; g++) begin
            cand  = l | 'h80 | 1;
            cyc  += 1;
            prime = 1'b1;
            d     = 3;
            while (d * d <= cand) begin
                cyc += 1 + W;
                if (cand % d == 0) begin
                    prime = 1'b0;
                    break;
                end
                d += 2;
            end
            cyc += 1;
            if (prime) begin
                cyc += 1;
                if (!have_p) begin
                    mp     = cand;
                    have_p = 1'b1;
                end else if (cand != mp) begin
                    mq = cand;
                    return;
                end
            end
            l = (l >> 1) ^ (((l & 1) != 0) ? 'hB8 : 0);
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_p", p, 0);
        check("rst_q", q, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // mode 0: one-cycle start pulse; 1: start held; 2: start toggled randomly while busy
    task automatic search(input int s, input int mode, input int exp_p_in, input int exp_q_in);
        int mp, mq, cyc, n, d0;
        model(s, mp, mq, cyc);
        if (exp_p_in >= 0) begin
            check("model_p", mp, exp_p_in);
            check("model_q", mq, exp_q_in);
        end
        d0 = done_cnt;
        @(negedge clk);
        seed  = W'(s);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (mode == 0) start = 1'b0;
        check("busy_rise", busy, 1);
        n = 0;
        while (done !== 1'b1 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
            if (mode == 2) start = $urandom_range(0, 1);
        end
        check("done_seen", done, 1);
        check("p", p, mp);
        check("q", q, mq);
        check("latency", n, cyc);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_low", done, 0);
        check("busy_low", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check("one_done", done_cnt - d0, 1);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        int s;
        int d0;
        n_cmp    = 0;
        n_fail   = 0;
        done_cnt = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        seed     = '0;

        do_reset();

        search('h03, 0, 131, 229);
        search('h00, 0, 151, 179);
        search('h01, 0, 151, 179);
        search('h03, 1, 131, 229);
        search('h03, 2, 131, 229);

        // Abandon a search partway through trial division.
        @(negedge clk);
        seed  = 8'h03;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        check("mid_busy", busy, 1);
        d0 = done_cnt;
        do_reset();
        repeat (40) @(posedge clk);
        #1;
        check("mid_no_done", done_cnt - d0, 0);
        check("mid_idle", busy, 0);
        search('h03, 0, 131, 229);

        for (int i = 0; i < 200; i++) begin
            s = $urandom_range(0, 255);
            search(s, 0, -1, -1);
            check("p_prime", is_prime(p), 1);
            check("q_prime", is_prime(q), 1);
            check("p_msb_lsb", {p[W-1], p[0]}, 2'b11);
            check("q_msb_lsb", {q[W-1], q[0]}, 2'b11);
            check("p_ne_q", (p != q), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/prime_pair_gen.md
# prime_pair_gen

Upstream stage of the RSA pipeline: from a seed, searches for two distinct full-width odd primes p and q. The search uses an LFSR candidate sequence and trial division, with a sequential remainder unit doing the division. Its `done` pulse drives the key-generation start, and `p`/`q` feed key generation directly. Deterministic for a given seed, so side-channel experiments are repeatable.

## Interface
- `WIDTH`, default 8: width of p, q and seed. Must be even and ≥ 4.
- `TAPS`, default `8'hB8`: Galois LFSR tap mask, right-shifting (x^8+x^6+x^5+x^4+1 for WIDTH=8).
- `clk`  input  1: single clock; all logic on the rising edge.
- `rst_n`  input  1: synchronous, active-low reset.
- `start`  input  1: begin a search. Sampled only in IDLE.
- `seed`  input  WIDTH: initial LFSR state, captured with `start`. Value 0 is replaced by 1.
- `p`  output  WIDTH: first prime found. Held until the next `done`.
- `q`  output  WIDTH: second prime found, q ≠ p. Held until the next `done`.
- `busy`  output  1: high in every state except IDLE.
- `done`  output  1: single-cycle pulse. p and q are valid in the same cycle.

## Operation
- **Candidate:** `cand = lfsr | (1 << (WIDTH-1)) | 1`. The MSB and LSB are forced to 1.
- **LFSR step:** `lfsr = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0)`.
- **Trial divisor:** d starts at 3 and increments by 2.
  - d is WIDTH/2+2 bits wide.
  - `d*d` is compared against `cand` at WIDTH+4 bits.
- **FSM states:**
  - IDLE: on `start` → load lfsr, set phase=P, go to CAND.
  - CAND (1 cycle): register cand, set d=3 → TEST.
  - TEST (1 cycle):
    - if `d*d > cand` → ACCEPT;
    - otherwise pulse `mod_start` → DIV.
  - DIV:
    - wait for `mod_done`;
    - if rem==0 → REJECT;
    - otherwise d += 2 → TEST.
  - REJECT (1 cycle): step lfsr → CAND.
  - ACCEPT (1 cycle):
    - phase P: set p = cand, phase = Q, step lfsr → CAND;
    - phase Q with cand == p: step lfsr → CAND;
    - phase Q otherwise: set q = cand → DONE.
  - DONE (1 cycle): `done` = 1 → IDLE.
- **Termination:** guaranteed. The LFSR visits every nonzero state, and the forced-MSB odd range contains primes.
- **`start` while busy:** ignored. Held-high `start` re-triggers only after returning to IDLE.
- **Note:** seeds 0 and 1 produce identical results.

## Timing
- **Reset:** p=0, q=0, done=0, busy=0, lfsr=1, state IDLE. Any in-flight search is abandoned with no `done`.
- **Start to busy:** `busy` rises the cycle after `start` is sampled.
- **Per-candidate cost:**
  - 1 cycle in CAND;
  - per divisor tried: 1 cycle in TEST plus WIDTH cycles in DIV;
  - 1 final cycle in TEST or REJECT;
  - 1 cycle in ACCEPT for accepted candidates.
- **Latency:** data-dependent by design. This is the intended timing variation.
- **Outputs:** `done` and updated p/q are registered outputs of DONE. `busy` falls in the cycle after `done`.
- **p update:** p changes at ACCEPT of phase P, so it is visible before `done`. Downstream must qualify on `done`.

## Structure
- **Shared package (`rsa_pkg`):**
  - FSM state enum (IDLE, CAND, TEST, DIV, REJECT, ACCEPT, DONE);
  - default LFSR tap constant for WIDTH=8.
- **Sub-module `seq_mod`:** restoring remainder of a WIDTH-bit dividend by a WIDTH-bit divisor.
  - `start` → `done` pulse exactly WIDTH cycles later, with `rem`.
  - Busy inputs are ignored.
  - Reusable by other stages.

## Test plan
- **Reset:** assert rst_n=0 for 2 cycles → p=0, q=0, done=0, busy=0.
- **Seed 0x03:** → p=131 (0x83), q=229 (0xE5).
  - Candidate 185 is rejected in between.
  - Exactly one `done` pulse; `busy` low the cycle after.
- **Seed 0x00:** → p=151, q=179, identical to seed 0x01.
  - Candidates 129, 185, 221 and 175 are rejected, in that order.
- **`start` held high / re-pulsed during busy:** no effect on the result (seed 0x03 → 131/229). A new search begins only after IDLE.
- **Reset mid-search:** rst_n=0 while in DIV.
  - All outputs return to 0 and no `done` is produced.
  - A subsequent seed 0x03 still yields 131/229.
- **Random seeds (≥200):** for every result, check against a reference model:
  - p and q are prime;
  - MSB and LSB of each are set;
  - p ≠ q;
  - exactly one `done` per accepted `start`.
